// File: rtl/snake_pkg.sv
// Shared heading type, direction constants and timing defaults
// for the snake game input path.
package snake_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_DOWN  = 2'd1;
  localparam dir_t DIR_LEFT  = 2'd2;
  localparam dir_t DIR_RIGHT = 2'd3;

  localparam int unsigned DEBOUNCE_10MS_100MHZ = 1000000;
  localparam int unsigned REPEAT_250MS_100MHZ  = 25000000;

  // U<->D and L<->R differ only in the low bit
  function automatic dir_t reverse_dir(input dir_t d);
    return {d[1], ~d[0]};
  endfunction

endpackage

// File: rtl/btn_debounce_cell.sv
// One button: 2-flop sync, debounce counter, rising-edge press pulse.
// Define AUTOREPEAT_EN to add a held-button repeat counter.
module btn_debounce_cell #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 3,
  parameter int unsigned REPEAT_CYCLES   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync0;
  logic             sync1;
  logic             db;
  logic             db_d;
  logic [CNT_W-1:0] cnt;
  logic             rise;
  logic             fire;

  assign rise = db & ~db_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      db    <= 1'b0;
      db_d  <= 1'b0;
      cnt   <= '0;
    end else begin
      sync0 <= btn;
      sync1 <= sync0;
      db_d  <= db;
      if (sync1 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        db  <= sync1;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

`ifdef AUTOREPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_CYCLES) + 1;
  localparam logic [RW-1:0] RPT_MAX = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rcnt;
  logic          rep_hit;

  assign rep_hit = db & db_d & (rcnt == RPT_MAX);
  assign fire    = rise | rep_hit;

  // restarts on the initial press so repeats are spaced from it
  always_ff @(posedge clk) begin
    if (rst || !db || rise || rep_hit) begin
      rcnt <= '0;
    end else begin
      rcnt <= rcnt + RW'(1);
    end
  end
`else
  assign fire = rise;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      press <= 1'b0;
    end else begin
      press <= fire;
    end
  end

endmodule

// File: rtl/dir_input_ctrl.sv
// Four debounced direction buttons feeding a last-press-wins request
// and a tick-aligned heading FSM. Define AUTOREPEAT_EN for held repeats.
module dir_input_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_100MHZ,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned REPEAT_CYCLES   = REPEAT_250MS_100MHZ,
  parameter dir_t        RST_DIR         = DIR_RIGHT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_u,
  input  logic       btn_d,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       move_tick,
  output logic [3:0] press,
  output logic [1:0] dir,
  output logic       dir_changed
);

  typedef enum logic {IDLE, ARMED} state_t;

  state_t     state_q;
  state_t     state_d;
  dir_t       pend_q;
  dir_t       pend_d;
  dir_t       dir_q;
  dir_t       dir_d;
  logic       chg_q;
  logic       chg_d;
  dir_t       req_dir;
  logic       legal;
  logic       pending_valid;
  logic [3:0] raw;

  assign raw = {btn_u, btn_d, btn_l, btn_r};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_cell (
      .clk  (clk),
      .rst  (rst),
      .btn  (raw[i]),
      .press(press[i])
    );
  end

  always_comb begin
    req_dir = DIR_RIGHT;
    priority case (1'b1)
      press[3]: req_dir = DIR_UP;
      press[2]: req_dir = DIR_DOWN;
      press[1]: req_dir = DIR_LEFT;
      default:  req_dir = DIR_RIGHT;
    endcase
  end

  assign pending_valid = (state_q == ARMED);
  assign legal = (pend_q != dir_q) && (pend_q != reverse_dir(dir_q));

  // a press in the same cycle as a tick defers to the next tick
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    dir_d   = dir_q;
    chg_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|press) begin
          pend_d  = req_dir;
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (|press) begin
          pend_d = req_dir;
        end else if (move_tick && pending_valid) begin
          state_d = IDLE;
          if (legal) begin
            dir_d = pend_q;
            chg_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= DIR_UP;
      dir_q   <= RST_DIR;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      dir_q   <= dir_d;
      chg_q   <= chg_d;
    end
  end

  assign dir         = dir_q;
  assign dir_changed = chg_q;

endmodule
